// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between requester A (load/store unit) and B (debug/DMA):
// grant, one issue cycle, then the synchronous read result with an rvalid pulse.
module dmem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_a,
    input  logic [3:0]  we_a,
    input  logic [2:0]  ls_a,
    input  logic [31:0] addr_a,
    input  logic [31:0] wdata_a,
    output logic        gnt_a,
    output logic        rvalid_a,
    output logic [31:0] rdata_a,

    input  logic        req_b,
    input  logic [3:0]  we_b,
    input  logic [2:0]  ls_b,
    input  logic [31:0] addr_b,
    input  logic [31:0] wdata_b,
    output logic        gnt_b,
    output logic        rvalid_b,
    output logic [31:0] rdata_b,

    output logic        mem_rd,
    output logic [3:0]  mem_we,
    output logic [2:0]  mem_load_select,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    state_e      state_q, state_d;
    port_e       owner_q, owner_d;
    port_e       last_q,  last_d;
    logic [3:0]  we_q,    we_d;
    logic [2:0]  ls_q,    ls_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic arb_en;
    logic pick_a;
    logic pick_b;

    // The port is free in IDLE and RESP; granting in RESP gives back-to-back accesses.
    always_comb begin
        arb_en = (state_q != S_ISSUE) && !rst;
        pick_a = arb_en && req_a && (!req_b || FIXED_PRIO || (last_q == PORT_B));
        pick_b = arb_en && req_b && !pick_a;
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        ls_d    = ls_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_a   = pick_a;
        gnt_b   = pick_b;

        if (pick_a || pick_b) begin
            state_d = S_ISSUE;
            owner_d = pick_a ? PORT_A : PORT_B;
            last_d  = pick_a ? PORT_A : PORT_B;
            we_d    = pick_a ? we_a    : we_b;
            ls_d    = pick_a ? ls_a    : ls_b;
            addr_d  = pick_a ? addr_a  : addr_b;
            wdata_d = pick_a ? wdata_a : wdata_b;
        end else begin
            case (state_q)
                S_ISSUE: state_d = S_RESP;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd          = 1'b0;
        mem_we          = 4'h0;
        mem_load_select = 3'd0;
        mem_addr        = 32'h0;
        mem_wdata       = 32'h0;
        rvalid_a        = 1'b0;
        rvalid_b        = 1'b0;
        rdata_a         = 32'h0;
        rdata_b         = 32'h0;

        case (state_q)
            S_ISSUE: begin
                // The memory only commits a write while rd is high.
                mem_rd          = 1'b1;
                mem_we          = we_q;
                mem_load_select = ls_q;
                mem_addr        = addr_q;
                mem_wdata       = wdata_q;
            end
            S_RESP: begin
                // Address and select stay put: the memory's output mux decodes them combinationally.
                mem_load_select = ls_q;
                mem_addr        = addr_q;
                if (owner_q == PORT_A) begin
                    rvalid_a = 1'b1;
                    rdata_a  = mem_rdata;
                end else begin
                    rvalid_b = 1'b1;
                    rdata_b  = mem_rdata;
                end
            end
            default: ;
        endcase

        busy = (state_q != S_IDLE);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= PORT_A;
            last_q  <= PORT_B;
            we_q    <= 4'h0;
            ls_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            ls_q    <= ls_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
